rsa_decrypt: RTL and testbench
==============================

Name: rsa_decrypt

Overview:
- Iterative RSA decryption engine: computes plaintext = ciphertext^d mod modulus with a start/done handshake.
- It is the receive-side counterpart of the rsa encryption block and has the same 32-bit operand convention.
- Uses right-to-left square-and-multiply.
- Two bit-serial interleaved modular multipliers run in parallel, so latency is fixed and independent of data.

Parameters:
WIDTH, 32, operand width in bits for ciphertext, exponent, modulus and plaintext.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
ciphertext  input  WIDTH  value to decrypt; captured when start is accepted.
priv_exponent  input  WIDTH  private exponent d; captured when start is accepted.
modulus  input  WIDTH  modulus N; captured when start is accepted.
plaintext  output  WIDTH  result; valid while done=1; held until the next result is written.
busy  output  1  high from the cycle after start acceptance through the DONE cycle.
done  output  1  single-cycle completion strobe.
error  output  1  qualifies done; 1 means the operands were rejected.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - State goes to IDLE.
  - plaintext=0, busy=0, done=0, error=0.
  - All internal registers are cleared.
  - An in-flight operation is aborted with no done strobe.
- States: IDLE, MUL, NEXT, DONE.
- IDLE:
  - busy=0. start=1 is accepted; inputs are latched into exp_r, n_r and base.
  - If modulus<2 or ciphertext>=modulus, go to DONE with error=1.
  - Otherwise set result=1, bit_cnt=0, mul_cnt=0 and go to MUL.
- MUL (exactly WIDTH cycles per exponent bit):
  - Two multipliers step MSB-first over the base bits: P1 = result*base mod N and P2 = base*base mod N.
  - Each cycle, for i = WIDTH-1 downto 0: acc = 2*acc + (base[i] ? operand : 0), then subtract N up to twice until acc<N.
  - acc registers are WIDTH+2 bits wide so the intermediate (<3N) never overflows.
  - Accumulators are cleared on MUL entry.
  - After WIDTH cycles go to NEXT.
- NEXT (1 cycle):
  - If exp_r[0]=1, result<=P1.
  - base<=P2.
  - exp_r shifts right by 1 and bit_cnt increments.
  - If bit_cnt==WIDTH-1, go to DONE; otherwise go to MUL.
- Fixed number of exponent bits:
  - All WIDTH exponent bits are always processed, including leading zeros, so latency is constant.
- DONE (1 cycle):
  - done=1, busy=1.
  - plaintext<=result (or 0 if error), error as determined.
  - Next state is IDLE.
- Latency:
  - Valid operands: start accepted at edge T, done=1 in cycle T + WIDTH*(WIDTH+1) + 1. For WIDTH=32 that is 1057 cycles.
  - Rejected operands: done=1, error=1 in cycle T+1.
- start while busy: ignored, with no queuing. Inputs may change freely after acceptance.
- exponent 0: result stays 1, so plaintext=1 (valid because N>=2).
- done and error are deasserted in every cycle other than DONE.
- Back-to-back operation: start may be asserted in the cycle after DONE, because the block is in IDLE again.

Test Plan:
- Reset, then start with C=13, d=7, N=33 -> done after 1057 cycles, plaintext=7, error=0 (round-trip of the encryptor's 7^3 mod 33).
- C=47, d=43, N=77 -> plaintext=5, error=0; busy high for the whole operation; done high exactly 1 cycle.
- C=10, d=5, N=11 -> plaintext=10. Then immediately C=13, d=0, N=33 -> plaintext=1.
- Rejection:
  - C=40, N=33 -> done and error in the cycle after start, plaintext=0.
  - N=1 -> same rejection response.
  - Next valid operation clears error.
- Pulse start again mid-operation with different operands -> ignored; the original result (7 for the first case) is returned at the original latency.
- Assert rst for 1 cycle at cycle 500 of an operation:
  - No done strobe.
  - Outputs read 0 after the reset edge.
  - A new start produces a correct result.

Source files
------------

// File: rtl/rsa_decrypt.sv
// Iterative RSA decryption engine: plaintext = ciphertext^d mod N using
// right-to-left square-and-multiply with two bit-serial modular multipliers.
module rsa_decrypt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ciphertext,
    input  logic [WIDTH-1:0] priv_exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] plaintext,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MUL, NEXT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, n_q, n_d, base_q, base_d, result_q, result_d;
    logic [AW-1:0]    acc1_q, acc1_d, acc2_q, acc2_d;
    logic [CW-1:0]    mul_cnt_q, mul_cnt_d, bit_cnt_q, bit_cnt_d, bit_idx;
    logic             err_q, err_d;
    logic [WIDTH-1:0] plaintext_q, plaintext_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             sel;

    // One interleaved step: acc = 2*acc + (sel ? op : 0), reduced below n (input < 3n).
    function automatic logic [AW-1:0] mod_step(input logic [AW-1:0]    acc,
                                               input logic [WIDTH-1:0] op,
                                               input logic             s,
                                               input logic [WIDTH-1:0] n);
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = AW'(n);
        t  = {acc[AW-2:0], 1'b0} + (s ? AW'(op) : AW'(0));
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    assign bit_idx = CW'(WIDTH - 1) - mul_cnt_q;
    assign sel     = base_q[bit_idx];

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        n_d         = n_q;
        base_d      = base_q;
        result_d    = result_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        mul_cnt_d   = mul_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_d       = err_q;
        plaintext_d = plaintext_q;
        busy_d      = (state_q != IDLE);
        done_d      = 1'b0;
        error_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d     = priv_exponent;
                    n_d       = modulus;
                    base_d    = ciphertext;
                    result_d  = WIDTH'(1);
                    bit_cnt_d = '0;
                    mul_cnt_d = '0;
                    acc1_d    = '0;
                    acc2_d    = '0;
                    if (modulus < WIDTH'(2) || ciphertext >= modulus) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc1_d    = mod_step(acc1_q, result_q, sel, n_q);
                acc2_d    = mod_step(acc2_q, base_q, sel, n_q);
                mul_cnt_d = mul_cnt_q + CW'(1);
                if (mul_cnt_q == CW'(WIDTH - 1)) begin
                    mul_cnt_d = '0;
                    state_d   = NEXT;
                end
            end
            NEXT: begin
                if (exp_q[0]) result_d = acc1_q[WIDTH-1:0];
                base_d    = acc2_q[WIDTH-1:0];
                exp_d     = exp_q >> 1;
                bit_cnt_d = bit_cnt_q + CW'(1);
                acc1_d    = '0;
                acc2_d    = '0;
                state_d   = (bit_cnt_q == CW'(WIDTH - 1)) ? DONE : MUL;
            end
            DONE: begin
                done_d      = 1'b1;
                error_d     = err_q;
                plaintext_d = err_q ? '0 : result_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            result_q    <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            mul_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            err_q       <= 1'b0;
            plaintext_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            n_q         <= n_d;
            base_q      <= base_d;
            result_q    <= result_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            mul_cnt_q   <= mul_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_q       <= err_d;
            plaintext_q <= plaintext_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign plaintext = plaintext_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed bench for rsa_decrypt: known RSA vectors, rejection, ignored start, mid-op reset.
module tb_rsa_decrypt;
    localparam int LAT = 1057;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ciphertext, priv_exponent, modulus;
    logic [31:0] plaintext;
    logic        busy, done, error;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rsa_decrypt #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ciphertext(ciphertext),
        .priv_exponent(priv_exponent), .modulus(modulus), .plaintext(plaintext),
        .busy(busy), .done(done), .error(error)
    );

    // Present operands with start for one edge (the acceptance edge).
    task automatic start_op(input logic [31:0] c, input logic [31:0] d, input logic [31:0] n);
        ciphertext = c; priv_exponent = d; modulus = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done; lat = cycles after acceptance (0 on timeout). Optional mid-op start pulse.
    task automatic wait_done(input int budget, input int pulse_at, output int lat,
                             output logic busy_all);
        lat = 0; busy_all = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (k == pulse_at) begin
                ciphertext = 32'd47; priv_exponent = 32'd43; modulus = 32'd77; start = 1'b1;
            end else if (k == pulse_at + 1) begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_all = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        ciphertext = '0; priv_exponent = '0; modulus = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (plaintext !== 32'd0) begin errors++; $display("FAIL reset_plaintext got %0d want 0", plaintext); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    endtask

    task automatic test_basic();
        int lat; logic ball;
        start_op(32'd13, 32'd7, 32'd33);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_accept got %b want 0", busy); end
        wait_done(LAT + 20, -10, lat, ball);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        checks++; if (plaintext !== 32'd7) begin errors++; $display("FAIL basic_plaintext got %0d want 7", plaintext); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %b want 0", error); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
        checks++; if (plaintext !== 32'd7) begin errors++; $display("FAIL basic_hold got %0d want 7", plaintext); end
    endtask

    task automatic test_busy_window();
        int lat; logic ball;
        start_op(32'd47, 32'd43, 32'd77);
        wait_done(LAT + 20, -10, lat, ball);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rsa77_latency got %0d want %0d", lat, LAT); end
        checks++; if (plaintext !== 32'd5) begin errors++; $display("FAIL rsa77_plaintext got %0d want 5", plaintext); end
        checks++; if (ball !== 1'b1) begin errors++; $display("FAIL rsa77_busy_whole got %b want 1", ball); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rsa77_done_width got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int lat; logic ball;
        start_op(32'd10, 32'd5, 32'd11);
        wait_done(LAT + 20, -10, lat, ball);
        checks++; if (plaintext !== 32'd10) begin errors++; $display("FAIL b2b_first got %0d want 10", plaintext); end
        start_op(32'd13, 32'd0, 32'd33);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b want 0", done); end
        wait_done(LAT + 20, -10, lat, ball);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        checks++; if (plaintext !== 32'd1) begin errors++; $display("FAIL b2b_exp0 got %0d want 1", plaintext); end
        @(posedge clk); #1;
    endtask

    task automatic test_reject();
        int lat; logic ball;
        start_op(32'd40, 32'd7, 32'd33);
        wait_done(10, -10, lat, ball);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rej_c_latency got %0d want 1", lat); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL rej_c_error got %b want 1", error); end
        checks++; if (plaintext !== 32'd0) begin errors++; $display("FAIL rej_c_plaintext got %0d want 0", plaintext); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rej_c_busy got %b want 1", busy); end
        @(posedge clk); #1;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rej_error_width got %b want 0", error); end
        start_op(32'd0, 32'd3, 32'd1);
        wait_done(10, -10, lat, ball);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rej_n_latency got %0d want 1", lat); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL rej_n_error got %b want 1", error); end
        checks++; if (plaintext !== 32'd0) begin errors++; $display("FAIL rej_n_plaintext got %0d want 0", plaintext); end
        @(posedge clk); #1;
        start_op(32'd10, 32'd5, 32'd11);
        wait_done(LAT + 20, -10, lat, ball);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rej_clear_error got %b want 0", error); end
        checks++; if (plaintext !== 32'd10) begin errors++; $display("FAIL rej_clear_plaintext got %0d want 10", plaintext); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat; logic ball;
        start_op(32'd13, 32'd7, 32'd33);
        wait_done(LAT + 20, 200, lat, ball);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
        checks++; if (plaintext !== 32'd7) begin errors++; $display("FAIL ignore_plaintext got %0d want 7", plaintext); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int lat; logic ball; logic saw_done;
        saw_done = 1'b0;
        start_op(32'd47, 32'd43, 32'd77);
        for (int k = 1; k < 500; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (plaintext !== 32'd0) begin errors++; $display("FAIL mrst_plaintext got %0d want 0", plaintext); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mrst_done_error got %b%b want 00", done, error); end
        for (int k = 0; k < LAT; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mrst_no_done got %b want 0", saw_done); end
        start_op(32'd13, 32'd7, 32'd33);
        wait_done(LAT + 20, -10, lat, ball);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL mrst_latency got %0d want %0d", lat, LAT); end
        checks++; if (plaintext !== 32'd7) begin errors++; $display("FAIL mrst_plaintext_after got %0d want 7", plaintext); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_window();
        test_back_to_back();
        test_reject();
        test_start_ignored();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
